// File: rtl/i2c_slave.sv
// i2c_slave: I2C target for register access with a 16-bit subaddress, oversampled on clk.
// The decoded bus accesses drive a local register file through single-cycle reg_wr/reg_rd strobes.
// Define I2C_SLAVE_GLITCH_FILTER_EN to put a 3-sample agreement filter on SCL and SDA.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i2c_scl,
  input  logic        i2c_sda_i,
  output logic        i2c_sda_o,
  output logic        i2c_sda_oe,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, SUBH, SUBH_ACK, SUBL, SUBL_ACK,
    WDATA, WDATA_ACK, RDATA, MACK, IGNORE
  } state_t;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_line, sda_line;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_rise, scl_fall, start_det, stop_det;

  // Two-flop synchronizers; the bus idles high so they reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i2c_scl};
      sda_sync_q <= {sda_sync_q[0], i2c_sda_i};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;
  logic       scl_filt_d, sda_filt_d;

  // A filtered line only moves once the current and two previous synced samples agree.
  always_comb begin
    scl_filt_d = scl_filt_q;
    sda_filt_d = sda_filt_q;
    if (scl_hist_q == {2{scl_sync_q[1]}}) scl_filt_d = scl_sync_q[1];
    if (sda_hist_q == {2{sda_sync_q[1]}}) sda_filt_d = sda_sync_q[1];
  end

  // Sample history and filtered-line registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
    end
  end

  assign scl_line = scl_filt_d;
  assign sda_line = sda_filt_d;
`else
  assign scl_line = scl_sync_q[1];
  assign sda_line = sda_sync_q[1];
`endif

  // Previous line values for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_line;
      sda_prev_q <= sda_line;
    end
  end

  assign scl_rise  = scl_line & ~scl_prev_q;
  assign scl_fall  = ~scl_line & scl_prev_q;
  assign start_det = scl_line & scl_prev_q & ~sda_line & sda_prev_q;
  assign stop_det  = scl_line & scl_prev_q & sda_line & ~sda_prev_q;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d, rx_byte;
  logic        rw_q, rw_d, ack_on_q, ack_on_d;
  logic        sda_o_q, sda_o_d, sda_oe_q, sda_oe_d;
  logic [15:0] reg_addr_q, reg_addr_d;
  logic [7:0]  reg_wdata_q, reg_wdata_d;
  logic        reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d, busy_q, busy_d;

  // Protocol next-state: START/STOP override everything, bits shift on SCL rise, SDA moves on SCL fall.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    rw_d        = rw_q;
    ack_on_d    = ack_on_q;
    sda_o_d     = sda_o_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    busy_d      = busy_q;
    rx_byte     = {rx_sr_q[6:0], sda_line};
    // Read data is valid the cycle after the strobe.
    if (reg_rd_q) tx_sr_d = reg_rdata;
    if (start_det) begin
      state_d   = DEV;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      sda_o_d   = 1'b1;
      busy_d    = 1'b0;
      ack_on_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      sda_o_d   = 1'b1;
      busy_d    = 1'b0;
      ack_on_d  = 1'b0;
    end else begin
      case (state_q)
        DEV, SUBH, SUBL, WDATA: begin
          if (scl_rise) begin
            rx_sr_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              ack_on_d  = 1'b0;
              case (state_q)
                DEV: begin
                  if (rx_byte[7:1] == SLAVE_ADDR) begin
                    state_d  = DEV_ACK;
                    rw_d     = rx_byte[0];
                    reg_rd_d = rx_byte[0];
                  end else begin
                    state_d = IGNORE;
                  end
                end
                SUBH: begin
                  reg_addr_d[15:8] = rx_byte;
                  state_d          = SUBH_ACK;
                end
                SUBL: begin
                  reg_addr_d[7:0] = rx_byte;
                  state_d         = SUBL_ACK;
                end
                default: begin
                  reg_wdata_d = rx_byte;
                  reg_wr_d    = 1'b1;
                  state_d     = WDATA_ACK;
                end
              endcase
            end
          end
        end
        DEV_ACK, SUBH_ACK, SUBL_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              ack_on_d = 1'b1;
              sda_oe_d = 1'b1;
              sda_o_d  = 1'b0;
              if (state_q == DEV_ACK) busy_d = 1'b1;
            end else begin
              ack_on_d = 1'b0;
              sda_oe_d = 1'b0;
              sda_o_d  = 1'b1;
              case (state_q)
                DEV_ACK: begin
                  if (rw_q) begin
                    // Release the ACK and put the first read bit on the bus in the same low phase.
                    state_d   = RDATA;
                    sda_oe_d  = 1'b1;
                    sda_o_d   = tx_sr_q[7];
                    tx_sr_d   = {tx_sr_q[6:0], 1'b1};
                    bit_cnt_d = 4'd1;
                  end else begin
                    state_d = SUBH;
                  end
                end
                SUBH_ACK: state_d = SUBL;
                SUBL_ACK: state_d = WDATA;
                default: begin
                  reg_addr_d = reg_addr_q + 16'd1;
                  state_d    = WDATA;
                end
              endcase
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              sda_o_d   = 1'b1;
              bit_cnt_d = 4'd0;
              state_d   = MACK;
            end else begin
              sda_oe_d  = 1'b1;
              sda_o_d   = tx_sr_q[7];
              tx_sr_d   = {tx_sr_q[6:0], 1'b1};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        MACK: begin
          if (scl_rise) begin
            if (!sda_line) begin
              reg_addr_d = reg_addr_q + 16'd1;
              reg_rd_d   = 1'b1;
              bit_cnt_d  = 4'd0;
              state_d    = RDATA;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      rx_sr_q     <= 8'd0;
      tx_sr_q     <= 8'hFF;
      rw_q        <= 1'b0;
      ack_on_q    <= 1'b0;
      sda_o_q     <= 1'b1;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= 16'd0;
      reg_wdata_q <= 8'd0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      rw_q        <= rw_d;
      ack_on_q    <= ack_on_d;
      sda_o_q     <= sda_o_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      busy_q      <= busy_d;
    end
  end

  assign i2c_sda_o  = sda_o_q;
  assign i2c_sda_oe = sda_oe_q;
  assign reg_addr   = reg_addr_q;
  assign reg_wdata  = reg_wdata_q;
  assign reg_wr     = reg_wr_q;
  assign reg_rd     = reg_rd_q;
  assign busy       = busy_q;

endmodule
